alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the complex-ALU operand/result handshake.
- Buffers operation commands in a small FIFO and drives them one at a time onto the ALU request pins (operation, a_valid, b_valid, start, m1, m2).
- Waits for the ALU's valid/error/result response and presents each response to a downstream consumer over a valid/ready port.
- Sits between a command source (CPU register bank or test sequencer) and the complex ALU.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT, 64, max cycles in DRIVE waiting for alu_valid before aborting; minimum 1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_op  in  2  ALU operation code.
- cmd_m1  in  16  operand A.
- cmd_m2  in  16  operand B.
- alu_operation  out  2  to ALU operation.
- alu_a_valid  out  1  to ALU a_valid.
- alu_b_valid  out  1  to ALU b_valid.
- alu_start  out  1  to ALU start.
- alu_m1  out  16  to ALU m1.
- alu_m2  out  16  to ALU m2.
- alu_valid  in  1  ALU result valid.
- alu_error  in  1  ALU error flag.
- alu_result  in  48  ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  48  captured result.
- rsp_error  out  1  captured ALU error, or timeout.
- rsp_timeout  out  1  response produced by timeout.
- busy  out  1  high when FSM is not IDLE or FIFO is non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; FSM to IDLE; timeout counter cleared.
  - All outputs 0, except cmd_ready=1.
  - Reset mid-transaction drops the in-flight command and any pending response with no further ALU activity.
- Command FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = !full, from the registered count. When full, a same-cycle pop does not enable a push.
  - Pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- FSM IDLE:
  - All alu_* outputs 0.
  - If FIFO non-empty: pop head into operand registers, go to DRIVE.
  - A command pushed at edge N is popped at edge N+1. alu_start is high from edge N+1.
- FSM DRIVE:
  - alu_start, alu_a_valid and alu_b_valid are held 1; alu_operation/alu_m1/alu_m2 are held stable from the operand registers.
  - The counter increments each cycle.
  - If alu_valid=1: capture alu_result and alu_error, set rsp_timeout=0, go to RESP.
  - Else if counter == TIMEOUT-1: set rsp_result=0, rsp_error=1, rsp_timeout=1, go to RESP.
  - alu_valid has priority over timeout in the same cycle.
- FSM RESP:
  - alu_* outputs forced 0, so the ALU sees start low for at least 1 cycle between commands.
  - rsp_valid=1; rsp_* remain stable until rsp_valid&&rsp_ready.
  - On handshake: rsp_valid=0 next cycle, counter cleared, go to IDLE.
  - Back-to-back commands therefore cost at least 2 idle cycles (RESP then IDLE) on the ALU side.
- alu_valid is ignored in IDLE and RESP; stale pulses are discarded.
- Minimum latency from cmd push to rsp_valid: 2 cycles plus the ALU response delay.
- The FIFO continues accepting commands during DRIVE and RESP.

Optional Feature:
- Macro: ALU_ISSUER_STATS_EN.
- When defined, adds two outputs:
  - stat_done (16 bits): counts completed responses at the rsp handshake.
  - stat_err (16 bits): counts handshakes with rsp_error=1, including timeouts.
- Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: push op=0, m1=16'h0102, m2=16'h0304; ALU model asserts alu_valid 3 cycles after start with result 48'h000000040006, error=0.
  - Required: alu_start high exactly from pop until valid.
  - Required: rsp_valid with rsp_result=48'h000000040006, rsp_error=0, rsp_timeout=0.
- FIFO full: hold rsp_ready=0, push 5 commands (op 0,1,2,3,0).
  - Required: cmd_ready=0 after 4 are buffered plus 1 in flight.
  - Required: after releasing rsp_ready, responses arrive in push order with matching ops on alu_operation.
- Timeout: TIMEOUT=8, ALU model never responds.
  - Required: rsp_valid 8 cycles after entering DRIVE, rsp_result=0, rsp_error=1, rsp_timeout=1.
  - Required: next command then issues normally.
- Error/priority: alu_valid=1 with alu_error=1 on the same cycle the counter hits TIMEOUT-1.
  - Required: rsp_timeout=0, rsp_error=1, rsp_result equals alu_result.
- Reset mid-DRIVE: drop rst_n for 1 cycle while alu_start=1 with 2 commands queued.
  - Required: alu_start drops immediately (async), busy=0, cmd_ready=1, no rsp_valid afterwards.
  - Required (ALU_ISSUER_STATS_EN): stat_done=0 and stat_err=0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// Complex-ALU command issuer: buffers commands, drives them one at a time onto the ALU pins and
// returns each ALU response (or a timeout) over a valid/ready port. Optional ALU_ISSUER_STATS_EN adds counters.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_m1,
    input  logic [15:0] cmd_m2,
    output logic [1:0]  alu_operation,
    output logic        alu_a_valid,
    output logic        alu_b_valid,
    output logic        alu_start,
    output logic [15:0] alu_m1,
    output logic [15:0] alu_m2,
    input  logic        alu_valid,
    input  logic        alu_error,
    input  logic [47:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [47:0] rsp_result,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        busy
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0] stat_done,
    output logic [15:0] stat_err
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] m1;
        logic [15:0] m2;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    state_t        state;
    logic [TW-1:0] tcnt;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);
    assign head      = mem[rd_ptr];

    // Command storage, no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_m1, cmd_m2};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: ALU pins and response registers are all driven from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tcnt          <= '0;
            alu_operation <= '0;
            alu_a_valid   <= 1'b0;
            alu_b_valid   <= 1'b0;
            alu_start     <= 1'b0;
            alu_m1        <= '0;
            alu_m2        <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_error     <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_operation <= head.op;
                        alu_m1        <= head.m1;
                        alu_m2        <= head.m2;
                        alu_a_valid   <= 1'b1;
                        alu_b_valid   <= 1'b1;
                        alu_start     <= 1'b1;
                        tcnt          <= '0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    tcnt <= tcnt + TW'(1);
                    // A real ALU answer wins over a timeout landing in the same cycle.
                    if (alu_valid || (tcnt == TO_LAST)) begin
                        rsp_valid     <= 1'b1;
                        rsp_result    <= alu_valid ? alu_result : '0;
                        rsp_error     <= alu_valid ? alu_error : 1'b1;
                        rsp_timeout   <= !alu_valid;
                        alu_operation <= '0;
                        alu_a_valid   <= 1'b0;
                        alu_b_valid   <= 1'b0;
                        alu_start     <= 1'b0;
                        alu_m1        <= '0;
                        alu_m2        <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        tcnt      <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUER_STATS_EN
    // Saturating completion / error counters, stepped on the response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_done <= '0;
            stat_err  <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
            if (rsp_error && (stat_err != 16'hFFFF)) stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer (DEPTH=4, TIMEOUT=8) with a small programmable ALU model.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_m1;
    logic [15:0] cmd_m2;
    logic [1:0]  alu_operation;
    logic        alu_a_valid;
    logic        alu_b_valid;
    logic        alu_start;
    logic [15:0] alu_m1;
    logic [15:0] alu_m2;
    logic        alu_valid  = 1'b0;
    logic        alu_error  = 1'b0;
    logic [47:0] alu_result = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [47:0] rsp_result;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        busy;
`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] stat_done;
    logic [15:0] stat_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    // ALU model controls (written by the main sequence only)
    int          model_delay  = 0;
    bit          model_echo   = 1'b0;
    bit          model_err    = 1'b0;
    logic [47:0] model_result = '0;
    // ALU model observations (written by the model only)
    int          age       = 0;
    int          start_len = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_m1(cmd_m1), .cmd_m2(cmd_m2),
        .alu_operation(alu_operation), .alu_a_valid(alu_a_valid), .alu_b_valid(alu_b_valid),
        .alu_start(alu_start), .alu_m1(alu_m1), .alu_m2(alu_m2),
        .alu_valid(alu_valid), .alu_error(alu_error), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy)
`ifdef ALU_ISSUER_STATS_EN
        , .stat_done(stat_done), .stat_err(stat_err)
`endif
    );

    // ALU model: answers model_delay cycles after start rises (0 = never); records start length.
    always @(posedge clk) begin
        #1;
        if (alu_start) begin
            age = age + 1;
        end else begin
            if (age != 0) start_len = age;
            age = 0;
        end
        alu_valid  = alu_start && (model_delay != 0) && (age == model_delay);
        alu_error  = alu_valid && model_err;
        alu_result = !alu_valid ? 48'd0 :
                     model_echo ? {14'd0, alu_operation, alu_m1, alu_m2} : model_result;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_m1    = a;
        cmd_m2    = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 60) begin
            step();
            cyc++;
        end
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [1:0]  op_i;
        logic [15:0] a_i;
        logic [15:0] b_i;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_m1 = '0; cmd_m2 = '0; rsp_ready = 1'b1;
        step();
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_alu_start", 64'(alu_start), 64'd0);
        rst_n = 1'b1;
        step();

        // Single op, ALU answers after 3 cycles of start
        model_delay = 3; model_echo = 1'b0; model_err = 1'b0; model_result = 48'h000000040006;
        push(2'd0, 16'h0102, 16'h0304);
        check("single_start_pre", 64'(alu_start), 64'd0);
        step();
        check("single_start",  64'(alu_start), 64'd1);
        check("single_abv",    64'({alu_a_valid, alu_b_valid}), 64'd3);
        check("single_m1",     64'(alu_m1), 64'h0102);
        check("single_m2",     64'(alu_m2), 64'h0304);
        wait_rsp("single_rsp", lat);
        check("single_lat",    64'(lat), 64'd3);
        check("single_len",    64'(start_len), 64'd3);
        check("single_result", 64'(rsp_result), 64'h000000040006);
        check("single_err",    64'(rsp_error), 64'd0);
        check("single_to",     64'(rsp_timeout), 64'd0);
        check("single_resp_start", 64'(alu_start), 64'd0);
        step();
        check("single_done_valid", 64'(rsp_valid), 64'd0);
        check("single_done_busy",  64'(busy), 64'd0);

        // FIFO full: 1 in flight + 4 buffered, extra push dropped
        rsp_ready = 1'b0; model_delay = 1; model_echo = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("full_ready_pre", 64'(cmd_ready), 64'd1);
            push(2'(i % 4), 16'h1000 + 16'(i), 16'h2000 + 16'(i));
        end
        check("full_ready",  64'(cmd_ready), 64'd0);
        check("full_busy",   64'(busy), 64'd1);
        check("full_rsp",    64'(rsp_valid), 64'd1);
        push(2'd3, 16'hDEAD, 16'hBEEF);
        check("full_ready2", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_i = 2'(i % 4);
            a_i  = 16'h1000 + 16'(i);
            b_i  = 16'h2000 + 16'(i);
            wait_rsp("order_rsp", lat);
            check("order_result", 64'(rsp_result), 64'({14'd0, op_i, a_i, b_i}));
            check("order_to",     64'(rsp_timeout), 64'd0);
            step();
        end
        repeat (4) step();
        check("order_drained_valid", 64'(rsp_valid), 64'd0);
        check("order_drained_busy",  64'(busy), 64'd0);

        // Timeout: ALU never answers
        model_delay = 0; model_echo = 1'b0;
        push(2'd2, 16'h0005, 16'h0007);
        wait_rsp("to_rsp", lat);
        check("to_lat",    64'(lat), 64'd9);
        check("to_len",    64'(start_len), 64'd8);
        check("to_result", 64'(rsp_result), 64'd0);
        check("to_err",    64'(rsp_error), 64'd1);
        check("to_flag",   64'(rsp_timeout), 64'd1);
        step();
        model_delay = 2; model_echo = 1'b1;
        push(2'd1, 16'h00AA, 16'h0055);
        wait_rsp("after_to_rsp", lat);
        check("after_to_result", 64'(rsp_result), 64'({14'd0, 2'd1, 16'h00AA, 16'h0055}));
        check("after_to_err",    64'(rsp_error), 64'd0);
        check("after_to_flag",   64'(rsp_timeout), 64'd0);
        step();

        // ALU error arriving on the last timeout cycle takes priority
        model_delay = 8; model_echo = 1'b0; model_err = 1'b1; model_result = 48'h123456789ABC;
        push(2'd3, 16'h0011, 16'h0022);
        wait_rsp("prio_rsp", lat);
        check("prio_lat",    64'(lat), 64'd9);
        check("prio_to",     64'(rsp_timeout), 64'd0);
        check("prio_err",    64'(rsp_error), 64'd1);
        check("prio_result", 64'(rsp_result), 64'h123456789ABC);
        step();
        model_err = 1'b0;
`ifdef ALU_ISSUER_STATS_EN
        check("stat_done", 64'(stat_done), 64'd9);
        check("stat_err",  64'(stat_err),  64'd2);
`endif

        // Reset while driving with two commands queued
        model_delay = 0;
        push(2'd0, 16'h0001, 16'h0002);
        push(2'd1, 16'h0003, 16'h0004);
        push(2'd2, 16'h0005, 16'h0006);
        check("rstmid_start_pre", 64'(alu_start), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_start",     64'(alu_start), 64'd0);
        check("rstmid_busy",      64'(busy), 64'd0);
        check("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef ALU_ISSUER_STATS_EN
        check("rstmid_stat_done", 64'(stat_done), 64'd0);
        check("rstmid_stat_err",  64'(stat_err),  64'd0);
`endif
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid || alu_start) seen = 1'b1;
        end
        check("rstmid_quiet", 64'(seen), 64'd0);
        check("rstmid_busy2", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
